// File: rtl/issue_queue.sv
// In-order issue buffer between instruction fetch and the RS/LSB.
// Accepts decoded instructions, allocates a ROB slot and renames rd on
// acceptance, keeps waiting operands up to date by snooping the CDB, and
// dispatches the oldest entry to RS or LSB once that target has room.
module issue_queue #(
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2,
  parameter int NUM_CDB = 2,
  parameter int OP_LOG  = 6,
  parameter int ROB_LOG = 4,
  parameter logic [OP_LOG-1:0] OP_LB = OP_LOG'(10),
  parameter logic [OP_LOG-1:0] OP_SW = OP_LOG'(17)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_LOG-1:0]          in_op,
  input  logic [31:0]                in_Vj,
  input  logic [31:0]                in_Vk,
  input  logic                       in_Rj,
  input  logic                       in_Rk,
  input  logic [ROB_LOG-1:0]         in_Qj,
  input  logic [ROB_LOG-1:0]         in_Qk,
  input  logic                       rob_full,
  input  logic [ROB_LOG-1:0]         rob_next,
  output logic                       rob_send_enable,
  output logic                       reg_send_enable,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*ROB_LOG-1:0] cdb_robid,
  input  logic [NUM_CDB*32-1:0]      cdb_value,
  input  logic                       rs_full,
  input  logic                       lsb_full,
  output logic                       rs_send_enable,
  output logic                       lsb_send_enable,
  output logic [OP_LOG-1:0]          out_op,
  output logic [ROB_LOG-1:0]         out_RobId,
  output logic [31:0]                out_Vj,
  output logic [31:0]                out_Vk,
  output logic                       out_Rj,
  output logic                       out_Rk,
  output logic [ROB_LOG-1:0]         out_Qj,
  output logic [ROB_LOG-1:0]         out_Qk
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [OP_LOG-1:0]  e_op  [DEPTH];
  logic [ROB_LOG-1:0] e_rob [DEPTH];
  logic [31:0]        e_vj  [DEPTH];
  logic [31:0]        e_vk  [DEPTH];
  logic               e_rj  [DEPTH];
  logic               e_rk  [DEPTH];
  logic [ROB_LOG-1:0] e_qj  [DEPTH];
  logic [ROB_LOG-1:0] e_qk  [DEPTH];

  logic [31:0]        snp_vj [DEPTH];
  logic [31:0]        snp_vk [DEPTH];
  logic               snp_rj [DEPTH];
  logic               snp_rk [DEPTH];

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W:0]     count;

  logic               enq;
  logic               deq;
  logic               head_lsb;
  logic               target_full;
  logic [32:0]        cap_j;
  logic [32:0]        cap_k;
  logic               new_rj;
  logic               new_rk;
  logic [31:0]        new_vj;
  logic [31:0]        new_vk;

  // Returns {hit, value} for the lowest-numbered CDB channel carrying tag q.
  function automatic logic [32:0] cdb_lookup(
    input logic [ROB_LOG-1:0]         q,
    input logic [NUM_CDB-1:0]         v,
    input logic [NUM_CDB*ROB_LOG-1:0] ids,
    input logic [NUM_CDB*32-1:0]      vals
  );
    logic [32:0] r;
    r = '0;
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (v[i] && (ids[i*ROB_LOG +: ROB_LOG] == q)) r = {1'b1, vals[i*32 +: 32]};
    end
    return r;
  endfunction

  // Handshake, head classification and incoming-operand capture from the CDB.
  always_comb begin
    in_ready        = rdy & ~rst & ~flush & ~rob_full & (count != FULL_COUNT);
    enq             = in_valid & in_ready;
    rob_send_enable = enq;
    reg_send_enable = enq;
    head_lsb        = (e_op[head] >= OP_LB) && (e_op[head] <= OP_SW);
    target_full     = head_lsb ? lsb_full : rs_full;
    deq             = rdy & ~flush & (count != '0) & ~target_full;
    cap_j           = cdb_lookup(in_Qj, cdb_valid, cdb_robid, cdb_value);
    cap_k           = cdb_lookup(in_Qk, cdb_valid, cdb_robid, cdb_value);
    new_rj          = in_Rj | cap_j[32];
    new_rk          = in_Rk | cap_k[32];
    new_vj          = (in_Rj | ~cap_j[32]) ? in_Vj : cap_j[31:0];
    new_vk          = (in_Rk | ~cap_k[32]) ? in_Vk : cap_k[31:0];
  end

  // Per-entry operand view with this cycle's CDB results already folded in.
  always_comb begin
    logic [32:0] hj;
    logic [32:0] hk;
    hj = '0;
    hk = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hj        = cdb_lookup(e_qj[k], cdb_valid, cdb_robid, cdb_value);
      hk        = cdb_lookup(e_qk[k], cdb_valid, cdb_robid, cdb_value);
      snp_rj[k] = e_rj[k] | hj[32];
      snp_rk[k] = e_rk[k] | hk[32];
      snp_vj[k] = (e_rj[k] | ~hj[32]) ? e_vj[k] : hj[31:0];
      snp_vk[k] = (e_rk[k] | ~hk[32]) ? e_vk[k] : hk[31:0];
    end
  end

  // Buffer state, pointers and the registered dispatch payload.
  always_ff @(posedge clk) begin
    if (rst || (rdy && flush)) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      rs_send_enable  <= 1'b0;
      lsb_send_enable <= 1'b0;
      out_op          <= '0;
      out_RobId       <= '0;
      out_Vj          <= '0;
      out_Vk          <= '0;
      out_Rj          <= 1'b0;
      out_Rk          <= 1'b0;
      out_Qj          <= '0;
      out_Qk          <= '0;
    end else if (rdy) begin
      for (int k = 0; k < DEPTH; k++) begin
        e_rj[k] <= snp_rj[k];
        e_rk[k] <= snp_rk[k];
        e_vj[k] <= snp_vj[k];
        e_vk[k] <= snp_vk[k];
      end
      if (enq) begin
        e_op[tail]  <= in_op;
        e_rob[tail] <= rob_next;
        e_qj[tail]  <= in_Qj;
        e_qk[tail]  <= in_Qk;
        e_rj[tail]  <= new_rj;
        e_rk[tail]  <= new_rk;
        e_vj[tail]  <= new_vj;
        e_vk[tail]  <= new_vk;
        tail        <= tail + PTR_W'(1);
      end
      rs_send_enable  <= deq & ~head_lsb;
      lsb_send_enable <= deq & head_lsb;
      if (deq) begin
        out_op    <= e_op[head];
        out_RobId <= e_rob[head];
        out_Qj    <= e_qj[head];
        out_Qk    <= e_qk[head];
        out_Rj    <= snp_rj[head];
        out_Rk    <= snp_rk[head];
        out_Vj    <= snp_vj[head];
        out_Vk    <= snp_vk[head];
        head      <= head + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: a scoreboard of expected dispatches is
// filled as instructions are accepted and drained by a monitor that fires on
// every send-enable pulse the consumer would accept.
module tb_issue_queue;

  localparam logic [5:0] OP_ALU = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd12;

  typedef struct packed {
    logic        lsb;
    logic [5:0]  op;
    logic [3:0]  rob;
    logic        rj;
    logic [31:0] vj;
    logic        rk;
    logic [31:0] vk;
    logic [3:0]  qj;
    logic [3:0]  qk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, in_valid, in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_Vj, in_Vk;
  logic        in_Rj, in_Rk;
  logic [3:0]  in_Qj, in_Qk;
  logic        rob_full;
  logic [3:0]  rob_next;
  logic        rob_send_enable, reg_send_enable;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_robid;
  logic [63:0] cdb_value;
  logic        rs_full, lsb_full;
  logic        rs_send_enable, lsb_send_enable;
  logic [5:0]  out_op;
  logic [3:0]  out_RobId;
  logic [31:0] out_Vj, out_Vk;
  logic        out_Rj, out_Rk;
  logic [3:0]  out_Qj, out_Qk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  issue_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_Vj(in_Vj), .in_Vk(in_Vk), .in_Rj(in_Rj), .in_Rk(in_Rk),
    .in_Qj(in_Qj), .in_Qk(in_Qk),
    .rob_full(rob_full), .rob_next(rob_next),
    .rob_send_enable(rob_send_enable), .reg_send_enable(reg_send_enable),
    .cdb_valid(cdb_valid), .cdb_robid(cdb_robid), .cdb_value(cdb_value),
    .rs_full(rs_full), .lsb_full(lsb_full),
    .rs_send_enable(rs_send_enable), .lsb_send_enable(lsb_send_enable),
    .out_op(out_op), .out_RobId(out_RobId), .out_Vj(out_Vj), .out_Vk(out_Vk),
    .out_Rj(out_Rj), .out_Rk(out_Rk), .out_Qj(out_Qj), .out_Qk(out_Qk)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [3:0] rob,
                               input logic rj, input logic [31:0] vj, input logic [3:0] qj,
                               input logic rk, input logic [31:0] vk, input logic [3:0] qk);
    in_valid = v;  in_op = op;  rob_next = rob;
    in_Rj = rj;    in_Vj = vj;  in_Qj = qj;
    in_Rk = rk;    in_Vk = vk;  in_Qk = qk;
  endtask

  task automatic pushExp(input logic [5:0] op, input logic [3:0] rob,
                         input logic rj, input logic [31:0] vj, input logic [3:0] qj,
                         input logic rk, input logic [31:0] vk, input logic [3:0] qk);
    exp_t e;
    e.lsb = (op >= 6'd10) && (op <= 6'd17);
    e.op = op;  e.rob = rob;
    e.rj = rj;  e.vj = vj;  e.qj = qj;
    e.rk = rk;  e.vk = vk;  e.qk = qk;
    sb.push_back(e);
  endtask

  // One accepted instruction: drive, confirm acceptance, record expectation.
  task automatic enq(input logic [5:0] op, input logic [3:0] rob,
                     input logic rj, input logic [31:0] vj, input logic [3:0] qj,
                     input logic rk, input logic [31:0] vk, input logic [3:0] qk,
                     input logic erj, input logic [31:0] evj,
                     input logic erk, input logic [31:0] evk, input logic push);
    @(negedge clk);
    applyStimulus(1'b1, op, rob, rj, vj, qj, rk, vk, qk);
    #1;
    checkOutput("enq_in_ready", in_ready, 1);
    checkOutput("enq_rob_send", rob_send_enable, 1);
    checkOutput("enq_reg_send", reg_send_enable, 1);
    if (push) pushExp(op, rob, erj, evj, qj, erk, evk, qk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #3;
    end
    checkOutput("drain_timeout", sb.size(), 0);
  endtask

  // Consumer-side monitor: a pulse counts once, on the first rdy cycle it is seen.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst && rdy && (rs_send_enable || lsb_send_enable)) begin
      checkOutput("dual_enable", rs_send_enable & lsb_send_enable, 0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_dispatch", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("disp_lsb", lsb_send_enable, e.lsb);
        checkOutput("disp_op", out_op, e.op);
        checkOutput("disp_robid", out_RobId, e.rob);
        checkOutput("disp_rj", out_Rj, e.rj);
        checkOutput("disp_rk", out_Rk, e.rk);
        checkOutput("disp_qj", out_Qj, e.qj);
        checkOutput("disp_qk", out_Qk, e.qk);
        if (e.rj) checkOutput("disp_vj", out_Vj, e.vj);
        if (e.rk) checkOutput("disp_vk", out_Vk, e.vk);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; rob_full = 1'b0;
    rs_full = 1'b0; lsb_full = 1'b0;
    cdb_valid = '0; cdb_robid = '0; cdb_value = '0;
    applyStimulus(1'b0, OP_ALU, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);

    // Reset state
    repeat (2) @(negedge clk);
    #1 checkOutput("reset_in_ready_low", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_rs_en", rs_send_enable, 0);
    checkOutput("reset_lsb_en", lsb_send_enable, 0);
    checkOutput("reset_robid", out_RobId, 0);

    // ROB full blocks acceptance
    @(negedge clk);
    rob_full = 1'b1;
    applyStimulus(1'b1, OP_ALU, 4'd9, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0);
    #1;
    checkOutput("robfull_in_ready", in_ready, 0);
    checkOutput("robfull_rob_send", rob_send_enable, 0);
    idle();
    rob_full = 1'b0;

    // 1: ALU op, ready operands, two-edge latency
    enq(OP_ALU, 4'd3, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0, 1'b1, 32'h11, 1'b1, 32'h22, 1'b1);
    idle();
    #1 checkOutput("t1_rs_en_early", rs_send_enable, 0);
    @(negedge clk);
    #1;
    checkOutput("t1_rs_en", rs_send_enable, 1);
    checkOutput("t1_robid", out_RobId, 3);
    waitDrain(10);

    // 2: load goes to LSB while RS is full
    @(negedge clk);
    rs_full = 1'b1;
    enq(OP_LW, 4'd4, 1'b1, 32'h100, 4'd0, 1'b1, 32'h8, 4'd0, 1'b1, 32'h100, 1'b1, 32'h8, 1'b1);
    idle();
    waitDrain(10);

    // 3: buffered unready operand woken by CDB channel 1
    enq(OP_ALU, 4'd6, 1'b0, 32'h0, 4'd5, 1'b1, 32'h7, 4'd0, 1'b1, 32'hDEAD, 1'b1, 32'h7, 1'b1);
    idle();
    @(negedge clk);
    cdb_valid = 2'b11;
    cdb_robid = {4'd5, 4'd2};
    cdb_value = {32'hDEAD, 32'hBEEF};
    @(negedge clk);
    cdb_valid = 2'b00;
    rs_full = 1'b0;
    waitDrain(10);

    // 3b: capture at enqueue, both channels match, lowest channel wins
    @(negedge clk);
    cdb_valid = 2'b11;
    cdb_robid = {4'd9, 4'd9};
    cdb_value = {32'h222, 32'h111};
    applyStimulus(1'b1, OP_ALU, 4'd7, 1'b1, 32'h5, 4'd0, 1'b0, 32'h0, 4'd9);
    #1;
    checkOutput("t3b_in_ready", in_ready, 1);
    pushExp(OP_ALU, 4'd7, 1'b1, 32'h5, 4'd0, 1'b1, 32'h111, 4'd9);
    idle();
    cdb_valid = 2'b00;
    waitDrain(10);

    // 4: fill to DEPTH, full judged before same-cycle dequeue, in-order drain
    @(negedge clk);
    rs_full = 1'b1;
    for (int i = 0; i < 4; i++)
      enq(OP_ALU, 4'(i), 1'b1, 32'(i + 32'h40), 4'd0, 1'b1, 32'h1, 4'd0,
          1'b1, 32'(i + 32'h40), 1'b1, 32'h1, 1'b1);
    @(negedge clk);
    rs_full = 1'b0;
    applyStimulus(1'b1, OP_ALU, 4'd4, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
    #1;
    checkOutput("t4_full_in_ready", in_ready, 0);
    checkOutput("t4_full_rob_send", rob_send_enable, 0);
    idle();
    waitDrain(20);
    enq(OP_LW, 4'd7, 1'b1, 32'h77, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h77, 1'b1, 32'h0, 1'b1);
    idle();
    waitDrain(10);

    // 5: flush with in_valid high wipes three buffered entries
    @(negedge clk);
    rs_full = 1'b1;
    for (int i = 0; i < 3; i++)
      enq(OP_ALU, 4'(8 + i), 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    applyStimulus(1'b1, OP_ALU, 4'd11, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
    #1;
    checkOutput("t5_flush_in_ready", in_ready, 0);
    checkOutput("t5_flush_rob_send", rob_send_enable, 0);
    checkOutput("t5_flush_reg_send", reg_send_enable, 0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    rs_full = 1'b0;
    #1;
    checkOutput("t5_rs_en", rs_send_enable, 0);
    checkOutput("t5_lsb_en", lsb_send_enable, 0);
    checkOutput("t5_robid", out_RobId, 0);
    repeat (4) @(negedge clk);
    enq(OP_ALU, 4'd12, 1'b1, 32'hC, 4'd0, 1'b1, 32'hD, 4'd0, 1'b1, 32'hC, 1'b1, 32'hD, 1'b1);
    idle();
    waitDrain(10);

    // 6: rdy low for three cycles mid-stream
    enq(OP_ALU, 4'd1, 1'b1, 32'hA1, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'hA1, 1'b1, 32'h0, 1'b1);
    enq(OP_ALU, 4'd2, 1'b1, 32'hA2, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'hA2, 1'b1, 32'h0, 1'b1);
    enq(OP_LW,  4'd3, 1'b1, 32'hA3, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'hA3, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rdy = 1'b0;
      in_valid = 1'b1;
      #1;
      checkOutput("t6_stall_rs_en", rs_send_enable, 1);
      checkOutput("t6_stall_robid", out_RobId, 2);
      checkOutput("t6_stall_in_ready", in_ready, 0);
      checkOutput("t6_stall_rob_send", rob_send_enable, 0);
    end
    @(negedge clk);
    rdy = 1'b1;
    in_valid = 1'b0;
    waitDrain(10);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
